// File: rtl/eco32f_lsu_pkg.sv
// Shared types, encodings and helpers for the eco32f data-side load/store unit.
// Lanes are big-endian: byte offset 0 lives in bits [31:24].
package eco32f_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    REFILL,
    UNC_READ,
    RD_DONE
  } lsu_state_e;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  // One posted store: word address, lane-replicated data and byte enables.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } sb_entry_t;

  function automatic logic [3:0] bsel(input logic [1:0] len, input logic [1:0] a);
    logic [3:0] s;
    case (len)
      LEN_BYTE: s = 4'b1000 >> a;
      LEN_HALF: s = a[1] ? 4'b0011 : 4'b1100;
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] bte_for(input int unsigned line_words);
    logic [1:0] b;
    case (line_words)
      4:       b = 2'b01;
      8:       b = 2'b10;
      16:      b = 2'b11;
      default: b = 2'b00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] len, input logic [31:0] d);
    logic [31:0] r;
    case (len)
      LEN_BYTE: r = {4{d[7:0]}};
      LEN_HALF: r = {2{d[15:0]}};
      default:  r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/eco32f_lsu_sb_if.sv
// Wishbone data-master bus of the load/store unit.
interface eco32f_lsu_sb_if;
  logic [31:0] dwbm_adr_o;
  logic [31:0] dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o;
  logic        dwbm_stb_o;
  logic        dwbm_cyc_o;
  logic [2:0]  dwbm_cti_o;
  logic [1:0]  dwbm_bte_o;
  logic [31:0] dwbm_dat_i;
  logic        dwbm_ack_i;
  logic        dwbm_err_i;

  modport master (
    output dwbm_adr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o,
           dwbm_stb_o, dwbm_cyc_o, dwbm_cti_o, dwbm_bte_o,
    input  dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );

  modport slave (
    input  dwbm_adr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o,
           dwbm_stb_o, dwbm_cyc_o, dwbm_cti_o, dwbm_bte_o,
    output dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );
endinterface

// File: rtl/eco32f_store_buffer.sv
// Synchronous FIFO of posted stores; head is the oldest entry.
// Push is ignored when full and pop when empty.
module eco32f_store_buffer
  import eco32f_lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  sb_entry_t push_entry,
  input  logic      pop,
  output sb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t      mem [DEPTH];
  logic [PW:0]    wr_ptr;
  logic [PW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/eco32f_lsu_sb.sv
// eco32f memory-stage load/store unit: write-through store buffer, line refill,
// uncached window and bus-error reporting over a Wishbone master port.
module eco32f_lsu_sb
  import eco32f_lsu_pkg::*;
#(
  parameter int          LINE_WORDS = 8,
  parameter int          SB_DEPTH   = 4,
  parameter logic [31:0] UNC_MASK   = 32'hf000_0000,
  parameter logic [31:0] UNC_MATCH  = 32'hf000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_len,
  input  logic        mem_sext,
  input  logic [31:0] mem_pa,
  input  logic [31:0] mem_wdata,
  input  logic        mem_exc,
  input  logic        mem_flush,
  output logic        lsu_stall,
  output logic [31:0] lsu_result,
  output logic        lsu_rd_err,
  output logic        lsu_wr_err,
  input  logic        dc_miss,
  input  logic [31:0] dc_rd_data,
  output logic [31:0] dc_wr_addr,
  output logic [31:0] dc_wr_data,
  output logic        dc_wr_en,
  output logic [3:0]  dc_wr_sel,
  output logic        dc_inval,
  eco32f_lsu_sb_if.master dwbm
);

  localparam int OFS_W = $clog2(LINE_WORDS);

  lsu_state_e          state_q, state_d;
  logic [29-OFS_W:0]   line_q;
  logic [OFS_W-1:0]    beat_q;
  logic [29:0]         unc_addr_q;
  logic [3:0]          unc_sel_q;
  logic [31:0]         rd_word_q;
  logic                rd_err_q;
  logic                wr_err_q;

  logic       live, uncached, rd_done, last_beat;
  logic       sb_push, sb_pop, sb_full, sb_empty;
  sb_entry_t  sb_in, sb_head;
  logic       start_refill, start_unc, beat_inc, rd_latch;
  logic       rd_err_set, wr_err_set, refill_wr, refill_inval, store_hit_wr;

  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;

  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign live      = mem_valid & ~mem_exc & ~mem_flush;
  assign uncached  = ((mem_pa & UNC_MASK) == UNC_MATCH);
  // rd_err_q doubles as a one-cycle stall release after a failed read.
  assign rd_done   = (state_q == RD_DONE) | rd_err_q;
  assign last_beat = (beat_q == OFS_W'(LINE_WORDS - 1));

  assign lsu_stall = live & ((mem_store & sb_full) |
                             (mem_load & (dc_miss | uncached) & ~rd_done));
  assign lsu_rd_err = rd_err_q;
  assign lsu_wr_err = wr_err_q;

  assign sb_push      = live & mem_store & ~sb_full;
  assign sb_in.addr   = mem_pa[31:2];
  assign sb_in.data   = replicate(mem_len, mem_wdata);
  assign sb_in.sel    = bsel(mem_len, mem_pa[1:0]);
  assign store_hit_wr = sb_push & ~dc_miss & ~uncached;

  eco32f_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (sb_push),
    .push_entry (sb_in),
    .pop        (sb_pop),
    .head       (sb_head),
    .full       (sb_full),
    .empty      (sb_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_err_q <= rd_err_set;
      wr_err_q <= wr_err_set;
      if (start_refill) beat_q <= '0;
      else if (beat_inc) beat_q <= beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start_refill) line_q <= mem_pa[31:OFS_W+2];
    if (start_unc) begin
      unc_addr_q <= mem_pa[31:2];
      unc_sel_q  <= bsel(mem_len, mem_pa[1:0]);
    end
    if (rd_latch) rd_word_q <= dwbm.dwbm_dat_i;
  end

  // Buffered stores always drain before any read is started, so reads see memory in program order.
  always_comb begin
    state_d      = state_q;
    sb_pop       = 1'b0;
    start_refill = 1'b0;
    start_unc    = 1'b0;
    beat_inc     = 1'b0;
    rd_latch     = 1'b0;
    rd_err_set   = 1'b0;
    wr_err_set   = 1'b0;
    refill_wr    = 1'b0;
    refill_inval = 1'b0;
    wb_adr       = '0;
    wb_dat       = '0;
    wb_sel       = '0;
    wb_we        = 1'b0;
    wb_stb       = 1'b0;
    wb_cyc       = 1'b0;
    wb_cti       = 3'b000;
    wb_bte       = 2'b00;
    case (state_q)
      IDLE: begin
        if (!sb_empty) begin
          state_d = WRITE;
        end else if (live && mem_load && uncached && !rd_err_q) begin
          state_d   = UNC_READ;
          start_unc = 1'b1;
        end else if (live && mem_load && dc_miss && !rd_err_q) begin
          state_d      = REFILL;
          start_refill = 1'b1;
        end
      end
      WRITE: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = 1'b1;
        wb_adr = {sb_head.addr, 2'b00};
        wb_dat = sb_head.data;
        wb_sel = sb_head.sel;
        wb_cti = CTI_END;
        if (dwbm.dwbm_ack_i) begin
          sb_pop  = 1'b1;
          state_d = IDLE;
        end else if (dwbm.dwbm_err_i) begin
          sb_pop     = 1'b1;
          wr_err_set = 1'b1;
          state_d    = IDLE;
        end
      end
      REFILL: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_adr = {line_q, beat_q, 2'b00};
        wb_sel = 4'b1111;
        wb_cti = last_beat ? CTI_END : CTI_INCR;
        wb_bte = bte_for(LINE_WORDS);
        if (dwbm.dwbm_ack_i) begin
          refill_wr = 1'b1;
          beat_inc  = 1'b1;
          if (last_beat) state_d = IDLE;
        end else if (dwbm.dwbm_err_i) begin
          refill_inval = 1'b1;
          rd_err_set   = 1'b1;
          state_d      = IDLE;
        end
      end
      UNC_READ: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_adr = {unc_addr_q, 2'b00};
        wb_sel = unc_sel_q;
        wb_cti = CTI_END;
        if (dwbm.dwbm_ack_i) begin
          rd_latch = 1'b1;
          state_d  = RD_DONE;
        end else if (dwbm.dwbm_err_i) begin
          rd_err_set = 1'b1;
          state_d    = IDLE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dwbm.dwbm_adr_o = wb_adr;
  assign dwbm.dwbm_dat_o = wb_dat;
  assign dwbm.dwbm_sel_o = wb_sel;
  assign dwbm.dwbm_we_o  = wb_we;
  assign dwbm.dwbm_stb_o = wb_stb;
  assign dwbm.dwbm_cyc_o = wb_cyc;
  assign dwbm.dwbm_cti_o = wb_cti;
  assign dwbm.dwbm_bte_o = wb_bte;

  // A refill beat owns the cache write port; a store hit only reaches it otherwise.
  always_comb begin
    dc_wr_en   = 1'b0;
    dc_inval   = 1'b0;
    dc_wr_addr = '0;
    dc_wr_data = '0;
    dc_wr_sel  = '0;
    if (refill_wr) begin
      dc_wr_en   = 1'b1;
      dc_wr_addr = {line_q, beat_q, 2'b00};
      dc_wr_data = dwbm.dwbm_dat_i;
      dc_wr_sel  = 4'b1111;
    end else if (refill_inval) begin
      dc_inval   = 1'b1;
      dc_wr_addr = {line_q, {OFS_W{1'b0}}, 2'b00};
    end else if (store_hit_wr) begin
      dc_wr_en   = 1'b1;
      dc_wr_addr = {mem_pa[31:2], 2'b00};
      dc_wr_data = sb_in.data;
      dc_wr_sel  = sb_in.sel;
    end
  end

  always_comb begin
    ld_word = (state_q == RD_DONE) ? rd_word_q : dc_rd_data;
    case (mem_pa[1:0])
      2'd0:    ld_byte = ld_word[31:24];
      2'd1:    ld_byte = ld_word[23:16];
      2'd2:    ld_byte = ld_word[15:8];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = mem_pa[1] ? ld_word[15:0] : ld_word[31:16];
    case (mem_len)
      LEN_BYTE: lsu_result = {{24{mem_sext & ld_byte[7]}}, ld_byte};
      LEN_HALF: lsu_result = {{16{mem_sext & ld_half[15]}}, ld_half};
      default:  lsu_result = ld_word;
    endcase
  end

endmodule

// File: tb/tb_eco32f_lsu_sb.sv
// Directed self-checking bench for eco32f_lsu_sb (LINE_WORDS=8, SB_DEPTH=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_eco32f_lsu_sb;
  import eco32f_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_load, mem_store, mem_sext, mem_exc, mem_flush;
  logic [1:0]  mem_len;
  logic [31:0] mem_pa, mem_wdata;
  logic        lsu_stall, lsu_rd_err, lsu_wr_err;
  logic [31:0] lsu_result;
  logic        dc_miss;
  logic [31:0] dc_rd_data;
  logic [31:0] dc_wr_addr, dc_wr_data;
  logic        dc_wr_en, dc_inval;
  logic [3:0]  dc_wr_sel;

  int checks = 0;
  int errors = 0;

  eco32f_lsu_sb_if dwbm();

  eco32f_lsu_sb #(
    .LINE_WORDS (8),
    .SB_DEPTH   (4),
    .UNC_MASK   (32'hf000_0000),
    .UNC_MATCH  (32'hf000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .mem_len    (mem_len),
    .mem_sext   (mem_sext),
    .mem_pa     (mem_pa),
    .mem_wdata  (mem_wdata),
    .mem_exc    (mem_exc),
    .mem_flush  (mem_flush),
    .lsu_stall  (lsu_stall),
    .lsu_result (lsu_result),
    .lsu_rd_err (lsu_rd_err),
    .lsu_wr_err (lsu_wr_err),
    .dc_miss    (dc_miss),
    .dc_rd_data (dc_rd_data),
    .dc_wr_addr (dc_wr_addr),
    .dc_wr_data (dc_wr_data),
    .dc_wr_en   (dc_wr_en),
    .dc_wr_sel  (dc_wr_sel),
    .dc_inval   (dc_inval),
    .dwbm       (dwbm)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic load, input logic store, input logic [1:0] len,
                               input logic sext, input logic [31:0] pa, input logic [31:0] wdata);
    mem_valid = 1'b1;
    mem_load  = load;
    mem_store = store;
    mem_len   = len;
    mem_sext  = sext;
    mem_pa    = pa;
    mem_wdata = wdata;
  endtask

  task automatic clearStimulus();
    mem_valid = 1'b0;
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_len   = LEN_WORD;
    mem_sext  = 1'b0;
    mem_pa    = '0;
    mem_wdata = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a strobed bus cycle, checks it, then answers with ack or err for one cycle.
  task automatic serveBeat(input string tag, input logic [31:0] exp_adr, input logic exp_we,
                           input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                           input logic [31:0] rd_data, input logic resp_err);
    int waited = 0;
    #1;
    while (!(dwbm.dwbm_cyc_o && dwbm.dwbm_stb_o) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput({tag, "_cyc"}, {31'd0, dwbm.dwbm_cyc_o & dwbm.dwbm_stb_o}, 32'd1);
    checkOutput({tag, "_adr"}, dwbm.dwbm_adr_o, exp_adr);
    checkOutput({tag, "_we"}, {31'd0, dwbm.dwbm_we_o}, {31'd0, exp_we});
    checkOutput({tag, "_sel"}, {28'd0, dwbm.dwbm_sel_o}, {28'd0, exp_sel});
    if (exp_we) checkOutput({tag, "_dat"}, dwbm.dwbm_dat_o, exp_dat);
    dwbm.dwbm_dat_i = rd_data;
    dwbm.dwbm_ack_i = ~resp_err;
    dwbm.dwbm_err_i = resp_err;
    @(negedge clk);
    dwbm.dwbm_ack_i = 1'b0;
    dwbm.dwbm_err_i = 1'b0;
    dwbm.dwbm_dat_i = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mem_exc = 1'b0;
    mem_flush = 1'b0;
    dc_miss = 1'b0;
    dc_rd_data = '0;
    dwbm.dwbm_dat_i = '0;
    dwbm.dwbm_ack_i = 1'b0;
    dwbm.dwbm_err_i = 1'b0;
    clearStimulus();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_cyc", {31'd0, dwbm.dwbm_cyc_o}, 32'd0);
    checkOutput("rst_stb", {31'd0, dwbm.dwbm_stb_o}, 32'd0);
    checkOutput("rst_we", {31'd0, dwbm.dwbm_we_o}, 32'd0);
    checkOutput("rst_dc", {30'd0, dc_wr_en, dc_inval}, 32'd0);
    checkOutput("rst_err", {30'd0, lsu_rd_err, lsu_wr_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Byte store hit to 0x1003
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, LEN_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    #1;
    checkOutput("sb_byte_stall", {31'd0, lsu_stall}, 32'd0);
    checkOutput("sb_byte_dcen", {31'd0, dc_wr_en}, 32'd1);
    checkOutput("sb_byte_dcsel", {28'd0, dc_wr_sel}, 32'h1);
    checkOutput("sb_byte_dcadr", dc_wr_addr, 32'h0000_1000);
    checkOutput("sb_byte_dcdat", dc_wr_data, 32'hA5A5_A5A5);
    @(negedge clk);
    clearStimulus();
    serveBeat("wr_byte", 32'h0000_1000, 1'b1, 4'b0001, 32'hA5A5_A5A5, 32'h0, 1'b0);

    // Half store at offset 2 lands in the low lanes
    applyStimulus(1'b0, 1'b1, LEN_HALF, 1'b0, 32'h0000_9002, 32'h0000_BEEF);
    #1;
    checkOutput("sb_half_dcsel", {28'd0, dc_wr_sel}, 32'h3);
    checkOutput("sb_half_dcdat", dc_wr_data, 32'hBEEF_BEEF);
    @(negedge clk);
    clearStimulus();
    serveBeat("wr_half", 32'h0000_9000, 1'b1, 4'b0011, 32'hBEEF_BEEF, 32'h0, 1'b0);

    // Five back-to-back stores with ack withheld
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, LEN_WORD, 1'b0, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
      #1;
      checkOutput("sb_fill_stall", {31'd0, lsu_stall}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, LEN_WORD, 1'b0, 32'h0000_0110, 32'h5555_5555);
    #1;
    checkOutput("sb_full_stall", {31'd0, lsu_stall}, 32'd1);
    checkOutput("sb_full_head", dwbm.dwbm_adr_o, 32'h0000_0100);
    @(negedge clk);
    dwbm.dwbm_ack_i = 1'b1;
    #1;
    checkOutput("sb_full_retire_stall", {31'd0, lsu_stall}, 32'd1);
    @(negedge clk);
    dwbm.dwbm_ack_i = 1'b0;
    #1;
    checkOutput("sb_space_stall", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    clearStimulus();
    for (int i = 1; i < 5; i++)
      serveBeat("wr_order", 32'h100 + 32'(4 * i), 1'b1, 4'b1111, 32'h1111_1111 * 32'(i + 1), 32'h0, 1'b0);

    // Half sext load miss at 0x2002: 8-beat wrapping refill
    applyStimulus(1'b1, 1'b0, LEN_HALF, 1'b1, 32'h0000_2002, 32'h0);
    dc_miss = 1'b1;
    #1;
    checkOutput("refill_stall", {31'd0, lsu_stall}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("refill_bte", {30'd0, dwbm.dwbm_bte_o}, 32'h2);
    checkOutput("refill_sel", {28'd0, dwbm.dwbm_sel_o}, 32'hF);
    for (int b = 0; b < 8; b++) begin
      dwbm.dwbm_dat_i = (b == 0) ? 32'h1234_8001 : 32'hC0DE_0000 + 32'(b);
      dwbm.dwbm_ack_i = 1'b1;
      #1;
      checkOutput("refill_adr", dwbm.dwbm_adr_o, 32'h2000 + 32'(4 * b));
      checkOutput("refill_cti", {29'd0, dwbm.dwbm_cti_o}, (b == 7) ? 32'h7 : 32'h2);
      checkOutput("refill_dcen", {31'd0, dc_wr_en}, 32'd1);
      checkOutput("refill_dcadr", dc_wr_addr, 32'h2000 + 32'(4 * b));
      @(negedge clk);
    end
    dwbm.dwbm_ack_i = 1'b0;
    dc_miss = 1'b0;
    dc_rd_data = 32'h1234_8001;
    #1;
    checkOutput("refill_done_cyc", {31'd0, dwbm.dwbm_cyc_o}, 32'd0);
    checkOutput("refill_done_stall", {31'd0, lsu_stall}, 32'd0);
    checkOutput("refill_result", lsu_result, 32'hFFFF_8001);
    @(negedge clk);

    // Big-endian lane selection on hits
    dc_rd_data = 32'h12F4_5678;
    applyStimulus(1'b1, 1'b0, LEN_BYTE, 1'b1, 32'h0000_8001, 32'h0);
    #1;
    checkOutput("hit_byte_sext", lsu_result, 32'hFFFF_FFF4);
    checkOutput("hit_stall", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, LEN_BYTE, 1'b0, 32'h0000_8003, 32'h0);
    #1;
    checkOutput("hit_byte_zext", lsu_result, 32'h0000_0078);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, LEN_HALF, 1'b0, 32'h0000_8000, 32'h0);
    #1;
    checkOutput("hit_half_hi", lsu_result, 32'h0000_12F4);
    @(negedge clk);

    // Uncached load behind a pending store
    applyStimulus(1'b0, 1'b1, LEN_WORD, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, LEN_WORD, 1'b0, 32'hF000_0010, 32'h0);
    #1;
    checkOutput("unc_stall", {31'd0, lsu_stall}, 32'd1);
    @(negedge clk);
    serveBeat("unc_wr_first", 32'h0000_3000, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
    serveBeat("unc_rd", 32'hF000_0010, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
    #1;
    checkOutput("unc_done_stall", {31'd0, lsu_stall}, 32'd0);
    checkOutput("unc_result", lsu_result, 32'hCAFE_F00D);
    @(negedge clk);
    clearStimulus();

    // Bus error on the third refill beat
    applyStimulus(1'b1, 1'b0, LEN_WORD, 1'b0, 32'h0000_4008, 32'h0);
    dc_miss = 1'b1;
    serveBeat("err_beat0", 32'h0000_4000, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0);
    serveBeat("err_beat1", 32'h0000_4004, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0);
    dwbm.dwbm_err_i = 1'b1;
    #1;
    checkOutput("err_adr", dwbm.dwbm_adr_o, 32'h0000_4008);
    checkOutput("err_inval", {31'd0, dc_inval}, 32'd1);
    checkOutput("err_inval_adr", dc_wr_addr, 32'h0000_4000);
    checkOutput("err_no_dcwr", {31'd0, dc_wr_en}, 32'd0);
    @(negedge clk);
    dwbm.dwbm_err_i = 1'b0;
    #1;
    checkOutput("err_cyc_drop", {31'd0, dwbm.dwbm_cyc_o}, 32'd0);
    checkOutput("err_rd_pulse", {31'd0, lsu_rd_err}, 32'd1);
    checkOutput("err_release", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    clearStimulus();
    dc_miss = 1'b0;
    #1;
    checkOutput("err_rd_once", {31'd0, lsu_rd_err}, 32'd0);
    @(negedge clk);

    // Buffered store bus error
    applyStimulus(1'b0, 1'b1, LEN_WORD, 1'b0, 32'h0000_7000, 32'h1234_5678);
    @(negedge clk);
    clearStimulus();
    serveBeat("wr_err", 32'h0000_7000, 1'b1, 4'b1111, 32'h1234_5678, 32'h0, 1'b1);
    #1;
    checkOutput("wr_err_pulse", {31'd0, lsu_wr_err}, 32'd1);
    checkOutput("wr_err_cyc", {31'd0, dwbm.dwbm_cyc_o}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("wr_err_once", {31'd0, lsu_wr_err}, 32'd0);

    // Reset mid-burst with a store buffered behind it
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, LEN_WORD, 1'b0, 32'h0000_5000, 32'h0);
    dc_miss = 1'b1;
    serveBeat("rst_beat0", 32'h0000_5000, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, LEN_WORD, 1'b0, 32'h0000_6000, 32'h6666_6666);
    dc_miss = 1'b0;
    @(negedge clk);
    clearStimulus();
    rst = 1'b1;
    #1;
    checkOutput("rst_sync_hold", {31'd0, dwbm.dwbm_cyc_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_burst_cyc", {31'd0, dwbm.dwbm_cyc_o}, 32'd0);
    checkOutput("rst_burst_stb", {31'd0, dwbm.dwbm_stb_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_sb_discard", {31'd0, dwbm.dwbm_cyc_o}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
